// File: rtl/prio_arbiter_enc.sv
// -----------------------------------------------------------------------------
// prio_arbiter_enc
//
// Registered N-way priority encoder / arbiter. Request pulses are captured into
// a sticky pending vector; one request is granted at a time on a valid/ready
// output, with up to one grant per cycle when the consumer keeps ready high.
//
// Selection:
//   MODE = 0 : fixed priority, highest set index wins.
//   MODE = 1 : round-robin. The search starts just below the last granted
//              index, goes down to 0, then wraps from N-1 down to last.
//
// Optional feature (macro PRIO_ARB_MASK_EN):
//   Adds input mask_in[N-1:0]. Masked bits still latch into pending but are
//   not eligible for selection until unmasked. A held grant is unaffected.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous, active-high reset
//   req_in       in   [N-1:0] request pulses (set pending bits)
//   mask_in      in   [N-1:0] eligibility mask (only with PRIO_ARB_MASK_EN)
//   ready_in     in   consumer accepts the current grant
//   valid_out    out  grant valid
//   idx_out      out  [IDXW-1:0] granted index (holds last value when idle)
//   onehot_out   out  [N-1:0] granted one-hot, zero when valid_out = 0
//   pending_out  out  [N-1:0] requests captured but not yet granted
// -----------------------------------------------------------------------------
module prio_arbiter_enc #(
    parameter int N    = 8,
    parameter int MODE = 0,
    parameter int IDXW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_in,
`ifdef PRIO_ARB_MASK_EN
    input  logic [N-1:0]    mask_in,
`endif
    input  logic            ready_in,
    output logic            valid_out,
    output logic [IDXW-1:0] idx_out,
    output logic [N-1:0]    onehot_out,
    output logic [N-1:0]    pending_out
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t          state_q;
    logic [N-1:0]    pending_q;
    logic [N-1:0]    pending_d;
    logic            valid_q;
    logic [IDXW-1:0] idx_q;
    logic [N-1:0]    onehot_q;
    logic [IDXW-1:0] last_q;

    logic [N-1:0]    cand;
    logic [IDXW-1:0] sel;
    logic [IDXW-1:0] sel_hi;
    logic [IDXW-1:0] sel_lo;
    logic            found_lo;
    logic [N-1:0]    sel_onehot;
    logic            any_cand;
    logic            load;
    logic [N-1:0]    loadmask;

    // Requests arriving this cycle are eligible immediately.
`ifdef PRIO_ARB_MASK_EN
    assign cand = (pending_q | req_in) & ~mask_in;
`else
    assign cand = pending_q | req_in;
`endif

    assign any_cand = |cand;

    // sel_hi: highest set index overall.
    // sel_lo: highest set index strictly below last_q.
    // Round-robin order (last-1 .. 0, then N-1 .. last) is exactly "sel_lo if
    // any exists, else sel_hi", since with nothing below last the highest
    // candidate overall is the first one found in the wrapped half.
    always_comb begin
        sel_hi   = '0;
        sel_lo   = '0;
        found_lo = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (cand[i]) begin
                sel_hi = IDXW'(i);
                if (IDXW'(i) < last_q) begin
                    sel_lo   = IDXW'(i);
                    found_lo = 1'b1;
                end
            end
        end
    end

    assign sel = ((MODE != 0) && found_lo) ? sel_lo : sel_hi;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_onehot
            assign sel_onehot[gi] = (sel == IDXW'(gi));
        end
    endgenerate

    // A new grant loads from IDLE whenever something is eligible, or from HOLD
    // once the current grant is accepted (back-to-back, one per cycle).
    assign load     = any_cand && ((state_q == ST_IDLE) || ready_in);
    assign loadmask = load ? sel_onehot : '0;

    // A re-request of the held bit lands back in pending, so it is served again.
    assign pending_d = (pending_q | req_in) & ~loadmask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            onehot_q  <= '0;
            last_q    <= '0;
        end else begin
            pending_q <= pending_d;
            if (load) begin
                state_q  <= ST_HOLD;
                valid_q  <= 1'b1;
                idx_q    <= sel;
                onehot_q <= sel_onehot;
                last_q   <= sel;
            end else if ((state_q == ST_HOLD) && ready_in) begin
                // Accepted with nothing left: drop valid, keep idx_q.
                state_q  <= ST_IDLE;
                valid_q  <= 1'b0;
                onehot_q <= '0;
            end
        end
    end

    assign valid_out   = valid_q;
    assign idx_out     = idx_q;
    assign onehot_out  = onehot_q;
    assign pending_out = pending_q;

endmodule

// File: tb/tb_prio_arbiter_enc.sv
// -----------------------------------------------------------------------------
// tb_prio_arbiter_enc
//
// Three instances: dut0 (N=8, fixed priority), dut1 (N=8, round-robin) and
// dut2 (N=5, round-robin, non power-of-two). Stimulus pushes the expected
// grant index sequence into a per-instance queue; a monitor per instance pops
// and compares on every accepted grant (valid_out & ready_in). Directed
// point checks cover reset, hold stability and pending contents.
// -----------------------------------------------------------------------------
module tb_prio_arbiter_enc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] req0, req1;
    logic [4:0] req2;
    logic       ready0, ready1, ready2;
    logic       v0, v1, v2;
    logic [2:0] idx0, idx1, idx2;
    logic [7:0] oh0, oh1, pend0, pend1;
    logic [4:0] oh2, pend2;
`ifdef PRIO_ARB_MASK_EN
    logic [7:0] mask0, mask1;
    logic [4:0] mask2;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int q0[$];
    int q1[$];
    int q2[$];

    prio_arbiter_enc #(.N(8), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .req_in(req0),
`ifdef PRIO_ARB_MASK_EN
        .mask_in(mask0),
`endif
        .ready_in(ready0), .valid_out(v0), .idx_out(idx0),
        .onehot_out(oh0), .pending_out(pend0)
    );

    prio_arbiter_enc #(.N(8), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .req_in(req1),
`ifdef PRIO_ARB_MASK_EN
        .mask_in(mask1),
`endif
        .ready_in(ready1), .valid_out(v1), .idx_out(idx1),
        .onehot_out(oh1), .pending_out(pend1)
    );

    prio_arbiter_enc #(.N(5), .MODE(1)) dut2 (
        .clk(clk), .rst(rst), .req_in(req2),
`ifdef PRIO_ARB_MASK_EN
        .mask_in(mask2),
`endif
        .ready_in(ready2), .valid_out(v2), .idx_out(idx2),
        .onehot_out(oh2), .pending_out(pend2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic no_grant_expected(input string name, input int idx);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got grant idx %0d required no grant", name, idx);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: sample on the falling edge, away from the active edge.
    always @(negedge clk) begin : mon0
        int e;
        if (!rst && v0 && ready0) begin
            if (q0.size() == 0) no_grant_expected("dut0 unexpected", int'(idx0));
            else begin
                e = q0.pop_front();
                $display("dut0 grant idx=%0d onehot=%b expected idx=%0d", idx0, oh0, e);
                check("dut0 idx", 64'(idx0), 64'(e));
                check("dut0 onehot", 64'(oh0), 64'(1) << e);
            end
        end
    end

    always @(negedge clk) begin : mon1
        int e;
        if (!rst && v1 && ready1) begin
            if (q1.size() == 0) no_grant_expected("dut1 unexpected", int'(idx1));
            else begin
                e = q1.pop_front();
                $display("dut1 grant idx=%0d onehot=%b expected idx=%0d", idx1, oh1, e);
                check("dut1 idx", 64'(idx1), 64'(e));
                check("dut1 onehot", 64'(oh1), 64'(1) << e);
            end
        end
    end

    always @(negedge clk) begin : mon2
        int e;
        if (!rst && v2 && ready2) begin
            if (q2.size() == 0) no_grant_expected("dut2 unexpected", int'(idx2));
            else begin
                e = q2.pop_front();
                $display("dut2 grant idx=%0d onehot=%b expected idx=%0d", idx2, oh2, e);
                check("dut2 idx", 64'(idx2), 64'(e));
                check("dut2 onehot", 64'(oh2), 64'(1) << e);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst = 1'b1;
        req0 = '0; req1 = '0; req2 = '0;
        ready0 = 1'b0; ready1 = 1'b0; ready2 = 1'b0;
`ifdef PRIO_ARB_MASK_EN
        mask0 = '0; mask1 = '0; mask2 = '0;
`endif
        repeat (2) tick();

        // Reset state
        check("reset valid0", 64'(v0), 64'(0));
        check("reset idx0", 64'(idx0), 64'(0));
        check("reset onehot0", 64'(oh0), 64'(0));
        check("reset pending0", 64'(pend0), 64'(0));
        check("reset valid1", 64'(v1), 64'(0));
        check("reset valid2", 64'(v2), 64'(0));

        // Reset mid-HOLD: grant 7 held, pending bit 0 queued, async reset clears
        rst = 1'b0;
        tick();
        req0 = 8'h80;
        tick();
        check("hold valid", 64'(v0), 64'(1));
        check("hold idx 7", 64'(idx0), 64'(7));
        req0 = 8'h01;
        tick();
        req0 = 8'h00;
        check("hold pending 01", 64'(pend0), 64'(8'h01));
        #2 rst = 1'b1;
        #1;
        check("async rst valid", 64'(v0), 64'(0));
        check("async rst pending", 64'(pend0), 64'(0));
        check("async rst onehot", 64'(oh0), 64'(0));
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("idle after rst valid", 64'(v0), 64'(0));
        check("idle after rst pending", 64'(pend0), 64'(0));

        // Fixed priority: 1010_0110 -> 7,5,2,1 back-to-back
        req0 = 8'hA6;
        ready0 = 1'b1;
        q0.push_back(7); q0.push_back(5); q0.push_back(2); q0.push_back(1);
        tick();
        req0 = 8'h00;
        repeat (4) tick();
        check("fixed done valid", 64'(v0), 64'(0));
        check("fixed done pending", 64'(pend0), 64'(0));

        // Hold stability: idx 2 held 5 cycles, later request for 7 queued
        ready0 = 1'b0;
        req0 = 8'h04;
        tick();
        req0 = 8'h00;
        for (int i = 0; i < 5; i++) begin
            check("stable idx 2", 64'(idx0), 64'(2));
            check("stable valid", 64'(v0), 64'(1));
            tick();
        end
        req0 = 8'h80;
        tick();
        req0 = 8'h00;
        check("no preempt idx 2", 64'(idx0), 64'(2));
        check("queued pending 80", 64'(pend0), 64'(8'h80));
        q0.push_back(2); q0.push_back(7);
        ready0 = 1'b1;
        tick();
        check("after accept idx 7", 64'(idx0), 64'(7));
        tick();
        check("stable done valid", 64'(v0), 64'(0));

        // Re-request of the held bit
        ready0 = 1'b0;
        req0 = 8'h08;
        tick();
        tick();
        req0 = 8'h00;
        check("rereq held idx 3", 64'(idx0), 64'(3));
        check("rereq pending 08", 64'(pend0), 64'(8'h08));
        q0.push_back(3); q0.push_back(3);
        ready0 = 1'b1;
        tick();
        tick();
        check("rereq done valid", 64'(v0), 64'(0));
        check("rereq done pending", 64'(pend0), 64'(0));

        // Round-robin: dut1 (N=8) and dut2 (N=5) with all bits requested
        for (int k = 0; k < 17; k++) q1.push_back(7 - (k % 8));
        for (int k = 0; k < 11; k++) q2.push_back(4 - (k % 5));
        req1 = 8'hFF;
        req2 = 5'h1F;
        ready1 = 1'b1;
        ready2 = 1'b1;
        repeat (7) tick();
        req2 = 5'h00;
        repeat (3) tick();
        req1 = 8'h00;
        repeat (8) tick();
        check("rr8 done valid", 64'(v1), 64'(0));
        check("rr8 done pending", 64'(pend1), 64'(0));
        check("rr5 done valid", 64'(v2), 64'(0));
        check("rr5 done pending", 64'(pend2), 64'(0));

`ifdef PRIO_ARB_MASK_EN
        // Masked bit 7 stays pending; bit 4 granted first
        ready0 = 1'b0;
        req0 = 8'h90;
        mask0 = 8'h80;
        tick();
        req0 = 8'h00;
        check("mask idx 4", 64'(idx0), 64'(4));
        check("mask pending 80", 64'(pend0), 64'(8'h80));
        mask0 = 8'h00;
        q0.push_back(4); q0.push_back(7);
        ready0 = 1'b1;
        tick();
        tick();
        check("mask done valid", 64'(v0), 64'(0));
`endif

        tick();
        check("dut0 queue drained", 64'(q0.size()), 64'(0));
        check("dut1 queue drained", 64'(q1.size()), 64'(0));
        check("dut2 queue drained", 64'(q2.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prio_arbiter_enc.md
Name: prio_arbiter_enc

Overview:
Parametrised, registered N-way priority encoder/arbiter; next generation of the team's 4-to-2 priority encoder.
Captures request pulses into a sticky pending vector and selects one request per grant: fixed-priority (highest index wins) or round-robin.
Presents the selected index and one-hot on a valid/ready output interface, with up to one grant per cycle.
Sits between interrupt/event sources and a single consumer (e.g. an interrupt controller or DMA channel selector).

Parameters:
N, 8, number of request lines (2..64)
MODE, 0, 0 = fixed priority (highest index wins), 1 = round-robin
IDXW, $clog2(N), index width (derived; do not override)

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  reset; asynchronous, active-high
req_in  input  N  request pulses; a 1 on any bit sets that pending bit
ready_in  input  1  consumer accepts the current grant
valid_out  output  1  grant valid
idx_out  output  IDXW  index of granted request
onehot_out  output  N  one-hot of granted request; all zeros when valid_out=0
pending_out  output  N  current pending vector (not yet granted)

Behaviour:
- Reset: pending=0, valid_out=0, idx_out=0, onehot_out=0, rr pointer last=0. Async assert clears state immediately regardless of clk; an in-flight grant is dropped.
- Candidate vector cand = pending | req_in; requests are eligible in the same cycle they arrive.
- FSM, 2 states:
  - IDLE: valid_out=0. If cand!=0, then at the edge: register sel into idx_out/onehot_out, valid_out<=1, go to HOLD.
  - HOLD: idx_out/onehot_out stable while ready_in=0.
    - On valid_out & ready_in with cand!=0: load the next sel in the same edge and stay in HOLD (back-to-back, 1 grant/cycle).
    - On valid_out & ready_in with cand=0: go to IDLE, valid_out<=0, onehot_out<=0; idx_out holds its last value.
- Pending update each edge: pending <= (pending | req_in) & ~loadmask.
  - loadmask = onehot of sel when a grant loads, else 0.
  - A request on the currently held (already granted) bit during HOLD re-sets pending; it is served again later. No request is lost.
  - Multiple pulses on a pending bit before grant merge into one.
- Selection:
  - MODE=0: sel = highest set index of cand. 4'b1010 -> 3, 4'b0011 -> 1.
  - MODE=1: search order last-1 down to 0, then N-1 down to last. last <= sel on every load. Reset last=0, so the first grant equals the highest index.
- Latency: req_in to valid_out is 1 cycle from IDLE.
- Boundary conditions:
  - All N bits set: MODE=0 serves N-1, N-2, ... only as those are cleared. New high requests preempt queued lower ones at the next load, never a held grant.
  - cand=0 in IDLE: no action.
  - N not a power of two: idx_out never exceeds N-1.

Optional Feature:
PRIO_ARB_MASK_EN. When defined, adds port mask_in input N.
- cand = (pending | req_in) & ~mask_in.
- Masked bits still latch into pending and remain there until unmasked and granted.
- mask_in does not affect a grant already held in HOLD.
When undefined: no mask_in port; all bits eligible.

Test Plan:
- Reset mid-HOLD, MODE=0, N=8: req_in=8'h80, hold ready_in=0, assert rst -> valid_out=0, pending_out=0 immediately. After release with no requests: stays idle.
- Fixed priority, MODE=0: one-cycle req_in=8'b1010_0110, ready_in=1 -> idx_out sequence 7,5,2,1 on consecutive cycles, then valid_out=0, pending_out=0.
- Hold stability: req_in=8'h04, ready_in=0 for 5 cycles, then req_in=8'h80 -> idx_out=2 held for 5 cycles. After accept: idx_out=7 next cycle.
- Round-robin, MODE=1: req_in=8'hFF every cycle, ready_in=1 -> idx_out 7,6,5,...,0,7 (wraps). Each index granted once per 8 cycles.
- Re-request of held bit: grant idx 3 held with ready_in=0, pulse req_in=8'h08 -> after accept, idx 3 is granted again next cycle.
- PRIO_ARB_MASK_EN defined: req_in=8'h90, mask_in=8'h80 -> idx_out=4, pending_out=8'h80. Clear mask -> next grant is idx 7.
